mic_volume_meter: RTL and testbench
===================================

Name: mic_volume_meter

Overview:
- Upstream stage of the game block; produces the 5-bit `volume` level that the mic-volume, record and game screens consume.
- Takes 12-bit microphone samples, qualified by a strobe, from the mic ADC sampler.
- Tracks the peak deviation from the DC midpoint over a fixed window of samples.
- Quantises the peak to a level 0..16 and applies attack-immediate / decay-by-step smoothing so the bar display does not flicker.

Parameters:
- WINDOW_SAMPLES, 4000: sample strobes per measurement window (4000 at 20 kHz gives 5 updates/s).
- MIDPOINT, 2048: ADC code for silence (DC bias of the mic).
- DECAY_STEP, 1: maximum drop of `volume` per window when the signal gets quieter.

Ports:
- clk  input  1  system clock (same clock as the game block).
- rst  input  1  synchronous, active-high reset.
- sample_valid  input  1  one-cycle strobe; `mic_in` is valid in that cycle.
- mic_in  input  12  unsigned ADC sample.
- volume  output  5  smoothed level, 0..16; drives the game block `volume` input.
- level_raw  output  5  unsmoothed level of the last completed window, 0..16.
- volume_valid  output  1  one-cycle pulse in the cycle `volume`/`level_raw` update.

Behaviour:
- Reset (rst=1 at a clk edge):
  - `volume`, `level_raw`, `volume_valid`, peak register and sample counter all go to 0.
  - A sample presented in the reset cycle is ignored.
  - Reset mid-window discards the partial window; the first window after reset starts with the next strobe.
- Amplitude, computed combinationally per sample:
  - a = mic_in - MIDPOINT if mic_in >= MIDPOINT, else MIDPOINT - mic_in.
  - Saturate a to 2047, so a is always 11 bits.
  - Example: mic_in=0 gives 2048, saturated to 2047.
- Peak tracking:
  - On each sample_valid: peak <= max(peak, a).
  - Counter cnt counts 0..WINDOW_SAMPLES-1.
  - Cycles without sample_valid leave peak and cnt unchanged.
- Window end: the sample_valid with cnt == WINDOW_SAMPLES-1.
  - The final sample is included: p = max(peak, a).
  - lvl = 16 if p == 2047, else p >> 7 (0..15).
  - Next edge:
    - level_raw <= lvl; volume_valid <= 1.
    - volume <= lvl if lvl >= volume.
    - Otherwise volume <= max(lvl, volume - DECAY_STEP).
    - peak <= 0; cnt <= 0.
  - Latency: outputs are updated at the first clk edge after the completing strobe, i.e. visible one cycle after it.
- volume_valid is high for exactly one cycle per window; it is 0 in every other cycle.
- Arithmetic:
  - The decay subtraction must not underflow; `volume` floor is 0.
  - `volume` never exceeds 16.
  - cnt width = clog2(WINDOW_SAMPLES).
- Back-to-back strobes (sample_valid high on consecutive cycles) must be accepted at full rate; no sample is dropped.
- No handshake back-pressure: outputs are simply held between updates.

Test Plan:
- WINDOW_SAMPLES=8, reset then 8 strobes of mic_in=2048 -> volume_valid pulses once, one cycle after the 8th strobe; level_raw=0, volume=0.
- WINDOW_SAMPLES=8, 7 strobes of 2048 then one strobe of 4095 (a=2047) -> level_raw=16, volume=16 (attack immediate; last sample counted).
- Window of peak mic_in=1024 (a=1024) -> level_raw=8, volume=8. Then 3 silent windows with DECAY_STEP=1 -> volume 7, 6, 5; level_raw=0 each.
- Assert rst after 5 strobes of 4095, release, then 8 strobes of 2048+300 (a=300) -> no pulse during reset; next pulse gives level_raw=2, volume=2; earlier peak discarded.
- Strobes with gaps (sample_valid every 3rd cycle) vs continuous strobes with the same data -> identical level_raw/volume sequence; pulse count equals strobes/8.
- mic_in=0 in one window -> a saturates to 2047, level_raw=16.

Source files
------------

// File: rtl/mic_volume_meter.sv
// Mic volume meter: windowed peak |mic_in - MIDPOINT| quantised to 0..16 with attack/decay smoothing.
// Outputs update one cycle after the window-completing strobe; accepts a strobe every cycle, no back-pressure.
module mic_volume_meter #(
    parameter int unsigned WINDOW_SAMPLES = 4000,
    parameter int unsigned MIDPOINT       = 2048,
    parameter int unsigned DECAY_STEP     = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sample_valid,
    input  logic [11:0] mic_in,
    output logic [4:0]  volume,
    output logic [4:0]  level_raw,
    output logic        volume_valid
);

    localparam int unsigned CNT_W = (WINDOW_SAMPLES > 1) ? $clog2(WINDOW_SAMPLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WINDOW_SAMPLES - 1);
    localparam logic [12:0]      MID      = 13'(MIDPOINT);
    // A step above the full scale behaves exactly like a step of 16.
    localparam logic [4:0]       STEP     = 5'((DECAY_STEP > 16) ? 16 : DECAY_STEP);
    localparam logic [10:0]      AMP_MAX  = 11'h7ff;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [10:0]      peak_q, peak_d;
    logic [4:0]       volume_q, volume_d;
    logic [4:0]       level_q, level_d;
    logic             vld_q, vld_d;

    logic [12:0] mic_ext;
    logic [12:0] diff;
    logic [10:0] amp;
    logic [10:0] peak_max;
    logic [4:0]  lvl;
    logic [4:0]  vol_dec;
    logic [4:0]  vol_next;

    always_comb begin
        mic_ext = {1'b0, mic_in};
        if (mic_ext >= MID) begin
            diff = mic_ext - MID;
        end else begin
            diff = MID - mic_ext;
        end
        amp      = (diff > 13'(AMP_MAX)) ? AMP_MAX : diff[10:0];
        peak_max = (amp > peak_q) ? amp : peak_q;
        lvl      = (peak_max == AMP_MAX) ? 5'd16 : {1'b0, peak_max[10:7]};

        // Decay floors at zero and never drops below the new window's level.
        vol_dec = (volume_q > STEP) ? (volume_q - STEP) : 5'd0;
        if (lvl >= volume_q) begin
            vol_next = lvl;
        end else if (lvl > vol_dec) begin
            vol_next = lvl;
        end else begin
            vol_next = vol_dec;
        end
    end

    always_comb begin
        cnt_d    = cnt_q;
        peak_d   = peak_q;
        volume_d = volume_q;
        level_d  = level_q;
        vld_d    = 1'b0;
        if (sample_valid) begin
            if (cnt_q == CNT_LAST) begin
                cnt_d    = '0;
                peak_d   = '0;
                level_d  = lvl;
                volume_d = vol_next;
                vld_d    = 1'b1;
            end else begin
                cnt_d  = cnt_q + 1'b1;
                peak_d = peak_max;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            peak_q   <= '0;
            volume_q <= '0;
            level_q  <= '0;
            vld_q    <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            peak_q   <= peak_d;
            volume_q <= volume_d;
            level_q  <= level_d;
            vld_q    <= vld_d;
        end
    end

    assign volume       = volume_q;
    assign level_raw    = level_q;
    assign volume_valid = vld_q;

endmodule

// File: tb/tb_mic_volume_meter.sv
// Scoreboard bench for mic_volume_meter with an 8-sample window.
module tb_mic_volume_meter;

    localparam int WIN = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sample_valid = 1'b0;
    logic [11:0] mic_in = '0;
    logic [4:0]  volume;
    logic [4:0]  level_raw;
    logic        volume_valid;

    mic_volume_meter #(
        .WINDOW_SAMPLES(WIN),
        .MIDPOINT      (2048),
        .DECAY_STEP    (1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .sample_valid(sample_valid),
        .mic_in      (mic_in),
        .volume      (volume),
        .level_raw   (level_raw),
        .volume_valid(volume_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        int lvl;
        int vol;
        int cyc;
    } exp_t;

    exp_t exp_q[$];
    int   rec_a[$];
    int   rec_b[$];
    int   rec_sel = 0;
    int   pulses  = 0;
    int   cyc     = 0;
    int   n_cmp   = 0;
    int   n_err   = 0;

    int m_peak = 0;
    int m_cnt  = 0;
    int m_vol  = 0;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (volume_valid) begin
            pulses++;
            if (exp_q.size() == 0) begin
                check_eq("spurious_pulse", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check_eq("pulse_cycle", cyc, e.cyc);
                check_eq("level_raw", int'(level_raw), e.lvl);
                check_eq("volume", int'(volume), e.vol);
            end
            if (rec_sel == 1) rec_a.push_back({level_raw, volume});
            if (rec_sel == 2) rec_b.push_back({level_raw, volume});
        end
    end

    // Reference model runs when the strobe is driven; called right after a posedge.
    task automatic strobe(input int v);
        int a, pm, lvl;
        exp_t e;
        sample_valid = 1'b1;
        mic_in       = 12'(v);
        a  = (v >= 2048) ? v - 2048 : 2048 - v;
        if (a > 2047) a = 2047;
        pm = (a > m_peak) ? a : m_peak;
        if (m_cnt == WIN - 1) begin
            lvl = (pm == 2047) ? 16 : pm / 128;
            if (lvl >= m_vol) m_vol = lvl;
            else m_vol = (m_vol - 1 > lvl) ? m_vol - 1 : lvl;
            e.lvl = lvl;
            e.vol = m_vol;
            e.cyc = cyc + 1;
            exp_q.push_back(e);
            m_peak = 0;
            m_cnt  = 0;
        end else begin
            m_peak = pm;
            m_cnt++;
        end
        @(posedge clk);
        #1;
        sample_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Holds reset for n cycles with a strobe of amplitude 2047 presented, which must be ignored.
    task automatic do_reset(input int n);
        rst          = 1'b1;
        sample_valid = 1'b1;
        mic_in       = 12'd0;
        idle(n);
        rst          = 1'b0;
        sample_valid = 1'b0;
        m_peak = 0;
        m_cnt  = 0;
        m_vol  = 0;
    endtask

    function automatic int pattern(input int i);
        if (i == 13) return 4095;
        return 2048 + ((i * 397) % 1900) - 950;
    endfunction

    initial begin
        idle(1);
        do_reset(2);
        check_eq("reset_volume", int'(volume), 0);
        check_eq("reset_level_raw", int'(level_raw), 0);
        check_eq("reset_volume_valid", int'(volume_valid), 0);

        // Silence, then a full-scale final sample (attack, last sample counted).
        for (int i = 0; i < WIN; i++) strobe(2048);
        idle(2);
        for (int i = 0; i < WIN - 1; i++) strobe(2048);
        strobe(4095);
        idle(2);

        // Level 8 window, then three silent windows decaying 7, 6, 5.
        do_reset(1);
        for (int i = 0; i < WIN; i++) strobe((i == 3) ? 1024 : 2048);
        for (int w = 0; w < 3; w++) for (int i = 0; i < WIN; i++) strobe(2048);
        idle(2);

        // Reset mid-window discards the partial loud window.
        for (int i = 0; i < 5; i++) strobe(4095);
        idle(1);
        exp_q.delete();
        do_reset(2);
        check_eq("midwin_reset_volume", int'(volume), 0);
        for (int i = 0; i < WIN; i++) strobe(2048 + 300);
        idle(2);

        // Continuous vs gapped strobes with identical data.
        do_reset(1);
        pulses  = 0;
        rec_sel = 1;
        for (int i = 0; i < 3 * WIN; i++) strobe(pattern(i));
        idle(2);
        check_eq("cont_pulse_count", pulses, 3);
        do_reset(1);
        pulses  = 0;
        rec_sel = 2;
        for (int i = 0; i < 3 * WIN; i++) begin
            strobe(pattern(i));
            idle(2);
        end
        idle(2);
        rec_sel = 0;
        check_eq("gap_pulse_count", pulses, 3);
        check_eq("gap_rec_len", rec_b.size(), rec_a.size());
        for (int i = 0; i < rec_a.size() && i < rec_b.size(); i++)
            check_eq("gap_vs_cont", rec_b[i], rec_a[i]);

        // mic_in = 0 saturates to full scale.
        do_reset(1);
        for (int i = 0; i < WIN; i++) strobe((i == 5) ? 0 : 2048);
        idle(3);

        check_eq("missed_pulses", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
